pipe_ctrl_tracker: RTL and testbench

//  Responder side of the pipeline controller's stage-control interface: holds the per-stage valid bits
//  and the control fields of the ID/EXE/MEM/WB pipeline registers, obeys the controller's *_rst/*_en,
//  and returns the valid flags and hazard feedback (dest reg, wen, load/mem-read) to the controller.

---
 rtl/pipe_ctrl_tracker_pkg.sv | 45 ++++
 rtl/pipe_ctrl_tracker_ctrl_stage_reg.sv | 53 +++++
 rtl/pipe_ctrl_tracker.sv | 162 ++++++++++++++++
 tb/tb_pipe_ctrl_tracker.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_tracker_pkg.sv
// ============================================================================
// Module  : pipe_ctrl_tracker_pkg
// Brief   : Shared decode constants and control-field packing for the
//           pipeline control tracker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_tracker_pkg;

    // Destination-register select codes produced by the ID decoder
    localparam logic [1:0] WB_ADDR_RD   = 2'b00;
    localparam logic [1:0] WB_ADDR_RT   = 2'b01;
    localparam logic [1:0] WB_ADDR_LINK = 2'b10;

    // Write-back data select
    localparam logic       WB_DATA_ALU  = 1'b0;
    localparam logic       WB_DATA_MEM  = 1'b1;

    localparam logic [4:0] LINK_REG     = 5'd31;

    // Packed control words carried by each stage; later stages drop the
    // fields nobody downstream consumes.
    localparam int EXE_W = 10;  // {regw_addr[4:0], wb_wen, mem_ren, mem_wen, is_load, wb_data_src}
    localparam int MEM_W = 9;   // {regw_addr[4:0], wb_wen, mem_ren, mem_wen, wb_data_src}
    localparam int WB_W  = 7;   // {regw_addr[4:0], wb_wen, wb_data_src}

    function automatic logic [4:0] sel_regw_addr(
        input logic [1:0] src,
        input logic [4:0] rd,
        input logic [4:0] rt
    );
        logic [4:0] addr;
        case (src)
            WB_ADDR_RD:   addr = rd;
            WB_ADDR_RT:   addr = rt;
            WB_ADDR_LINK: addr = LINK_REG;
            default:      addr = 5'd0;
        endcase
        return addr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_tracker_ctrl_stage_reg.sv
// ============================================================================
// Module  : ctrl_stage_reg
// Brief   : One pipeline control register with valid bit; flush beats enable.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_stage_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_rst,
    input  logic             s_en,
    input  logic [WIDTH-1:0] d,
    input  logic             valid_in,
    output logic [WIDTH-1:0] q,
    output logic             valid_out
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_d;
    logic             valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (s_rst) begin
            data_d  = '0;
            valid_d = 1'b0;
        end else if (s_en) begin
            data_d  = d;
            valid_d = valid_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q         = data_q;
    assign valid_out = valid_q;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl_tracker.sv
// ============================================================================
// Module  : pipe_ctrl_tracker
// Brief   : Tracks per-stage valid bits and control fields of the ID/EXE/MEM/WB
//           pipeline registers, returns hazard feedback, counts retirements.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_tracker
    import pipe_ctrl_tracker_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_rst,
    input  logic             if_en,
    input  logic             id_rst,
    input  logic             id_en,
    input  logic             exe_rst,
    input  logic             exe_en,
    input  logic             mem_rst,
    input  logic             mem_en,
    input  logic             wb_rst,
    input  logic             wb_en,
    input  logic [31:0]      inst_id,
    input  logic [1:0]       wb_addr_src,
    input  logic             wb_wen,
    input  logic             mem_ren,
    input  logic             mem_wen,
    input  logic             is_load,
    input  logic             wb_data_src,
    output logic             if_valid,
    output logic             id_valid,
    output logic             exe_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic [4:0]       regw_addr_exe,
    output logic [4:0]       regw_addr_mem,
    output logic [4:0]       regw_addr_wb,
    output logic             wb_wen_exe,
    output logic             wb_wen_mem,
    output logic             wb_wen_wb,
    output logic             is_load_exe,
    output logic             mem_ren_mem,
    output logic             mem_wen_mem,
    output logic             wb_data_src_wb,
    output logic [CNT_W-1:0] retired
);

    logic             if_valid_d;
    logic             if_valid_q;
    logic             id_valid_d;
    logic             id_valid_q;
    logic [CNT_W-1:0] retired_d;
    logic [CNT_W-1:0] retired_q;

    logic [EXE_W-1:0] exe_d_vec;
    logic [EXE_W-1:0] exe_q_vec;
    logic [MEM_W-1:0] mem_d_vec;
    logic [MEM_W-1:0] mem_q_vec;
    logic [WB_W-1:0]  wb_d_vec;
    logic [WB_W-1:0]  wb_q_vec;
    logic             exe_valid_q;
    logic             mem_valid_q;
    logic             wb_valid_q;

    // Only the rd/rt fields of the instruction matter to destination tracking
    logic             unused_inst_bits;
    assign unused_inst_bits = ^{inst_id[31:21], inst_id[10:0]};

    always_comb begin
        if_valid_d = if_valid_q;
        id_valid_d = id_valid_q;
        retired_d  = retired_q;
        if (if_rst) begin
            if_valid_d = 1'b0;
        end else if (if_en) begin
            if_valid_d = 1'b1;
        end
        if (id_rst) begin
            id_valid_d = 1'b0;
        end else if (id_en) begin
            id_valid_d = if_valid_q;
        end
        if (wb_valid_q && wb_en && !wb_rst) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid_q <= 1'b0;
            id_valid_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            if_valid_q <= if_valid_d;
            id_valid_q <= id_valid_d;
            retired_q  <= retired_d;
        end
    end

    assign exe_d_vec = {sel_regw_addr(wb_addr_src, inst_id[15:11], inst_id[20:16]),
                        wb_wen, mem_ren, mem_wen, is_load, wb_data_src};
    assign mem_d_vec = {exe_q_vec[9:2], exe_q_vec[0]};
    assign wb_d_vec  = {mem_q_vec[8:3], mem_q_vec[0]};

    ctrl_stage_reg #(.WIDTH(EXE_W)) u_exe (
        .clk       (clk),
        .rst       (rst),
        .s_rst     (exe_rst),
        .s_en      (exe_en),
        .d         (exe_d_vec),
        .valid_in  (id_valid_q),
        .q         (exe_q_vec),
        .valid_out (exe_valid_q)
    );

    ctrl_stage_reg #(.WIDTH(MEM_W)) u_mem (
        .clk       (clk),
        .rst       (rst),
        .s_rst     (mem_rst),
        .s_en      (mem_en),
        .d         (mem_d_vec),
        .valid_in  (exe_valid_q),
        .q         (mem_q_vec),
        .valid_out (mem_valid_q)
    );

    ctrl_stage_reg #(.WIDTH(WB_W)) u_wb (
        .clk       (clk),
        .rst       (rst),
        .s_rst     (wb_rst),
        .s_en      (wb_en),
        .d         (wb_d_vec),
        .valid_in  (mem_valid_q),
        .q         (wb_q_vec),
        .valid_out (wb_valid_q)
    );

    assign if_valid       = if_valid_q;
    assign id_valid       = id_valid_q;
    assign exe_valid      = exe_valid_q;
    assign mem_valid      = mem_valid_q;
    assign wb_valid       = wb_valid_q;

    // A bubble must never look like a pending write to the hazard logic
    assign regw_addr_exe  = exe_q_vec[9:5];
    assign wb_wen_exe     = exe_q_vec[4] & exe_valid_q;
    assign is_load_exe    = exe_q_vec[1] & exe_valid_q;
    assign regw_addr_mem  = mem_q_vec[8:4];
    assign wb_wen_mem     = mem_q_vec[3] & mem_valid_q;
    assign mem_ren_mem    = mem_q_vec[2] & mem_valid_q;
    assign mem_wen_mem    = mem_q_vec[1] & mem_valid_q;
    assign regw_addr_wb   = wb_q_vec[6:2];
    assign wb_wen_wb      = wb_q_vec[1] & wb_valid_q;
    assign wb_data_src_wb = wb_q_vec[0];
    assign retired        = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_tracker.sv
// ============================================================================
// Module  : tb_pipe_ctrl_tracker
// Brief   : Directed scenarios plus randomized run against a stage-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl_tracker;
    import pipe_ctrl_tracker_pkg::*;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en;
    logic [31:0] inst_id;
    logic [1:0]  wb_addr_src;
    logic wb_wen, mem_ren, mem_wen, is_load, wb_data_src;
    logic if_valid, id_valid, exe_valid, mem_valid, wb_valid;
    logic [4:0] regw_addr_exe, regw_addr_mem, regw_addr_wb;
    logic wb_wen_exe, wb_wen_mem, wb_wen_wb, is_load_exe, mem_ren_mem, mem_wen_mem, wb_data_src_wb;
    logic [CW-1:0] retired;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       v;
        logic [4:0] ra;
        logic       wen;
        logic       ren;
        logic       mwen;
        logic       ld;
        logic       ds;
    } stg_t;

    logic m_if, m_id;
    stg_t m_exe, m_mem, m_wb;
    int   m_ret;

    pipe_ctrl_tracker #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .if_rst(if_rst), .if_en(if_en), .id_rst(id_rst), .id_en(id_en),
        .exe_rst(exe_rst), .exe_en(exe_en), .mem_rst(mem_rst), .mem_en(mem_en),
        .wb_rst(wb_rst), .wb_en(wb_en),
        .inst_id(inst_id), .wb_addr_src(wb_addr_src), .wb_wen(wb_wen),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .is_load(is_load), .wb_data_src(wb_data_src),
        .if_valid(if_valid), .id_valid(id_valid), .exe_valid(exe_valid),
        .mem_valid(mem_valid), .wb_valid(wb_valid),
        .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem), .regw_addr_wb(regw_addr_wb),
        .wb_wen_exe(wb_wen_exe), .wb_wen_mem(wb_wen_mem), .wb_wen_wb(wb_wen_wb),
        .is_load_exe(is_load_exe), .mem_ren_mem(mem_ren_mem), .mem_wen_mem(mem_wen_mem),
        .wb_data_src_wb(wb_data_src_wb), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ref_dest(input logic [1:0] src, input logic [31:0] inst);
        case (src)
            2'd0:    return inst[15:11];
            2'd1:    return inst[20:16];
            2'd2:    return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_if = 1'b0; m_id = 1'b0; m_exe = '0; m_mem = '0; m_wb = '0; m_ret = 0;
    endtask

    // Apply one clock edge's worth of stage rules to the model using current inputs
    task automatic model_edge();
        stg_t n_exe, n_mem, n_wb;
        logic n_if, n_id;
        n_if  = if_rst  ? 1'b0 : (if_en  ? 1'b1 : m_if);
        n_id  = id_rst  ? 1'b0 : (id_en  ? m_if : m_id);
        n_exe = exe_rst ? '0 : (exe_en ? '{m_id, ref_dest(wb_addr_src, inst_id), wb_wen,
                                          mem_ren, mem_wen, is_load, wb_data_src} : m_exe);
        n_mem = mem_rst ? '0 : (mem_en ? m_exe : m_mem);
        n_wb  = wb_rst  ? '0 : (wb_en  ? m_mem : m_wb);
        if (m_wb.v && wb_en && !wb_rst) m_ret = (m_ret + 1) % (1 << CW);
        m_if = n_if; m_id = n_id; m_exe = n_exe; m_mem = n_mem; m_wb = n_wb;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_decode(input logic [31:0] inst, input logic [1:0] src, input logic wen,
                              input logic ren, input logic mwen, input logic ld, input logic ds);
        inst_id = inst; wb_addr_src = src; wb_wen = wen;
        mem_ren = ren; mem_wen = mwen; is_load = ld; wb_data_src = ds;
    endtask

    task automatic defaults();
        {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = '0;
        {if_en, id_en, exe_en, mem_en, wb_en}      = '1;
        set_decode(32'h0, WB_ADDR_RD, 1'b0, 1'b0, 1'b0, 1'b0, WB_DATA_ALU);
    endtask

    task automatic do_reset();
        defaults();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [30:0] obs;
        defaults();
        model_reset();
        #12;
        obs = {if_valid, id_valid, exe_valid, mem_valid, wb_valid, regw_addr_exe, regw_addr_mem,
               regw_addr_wb, wb_wen_exe, wb_wen_mem, wb_wen_wb, is_load_exe, mem_ren_mem,
               mem_wen_mem, wb_data_src_wb, retired};
        checks++;
        if (obs !== 31'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", obs);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [9:0] obs;
        do_reset();
        set_decode(32'h00002020, WB_ADDR_RD, 1'b1, 1'b0, 1'b0, 1'b0, WB_DATA_ALU);
        repeat (6) tick();
        checks++;
        if ({wb_valid, wb_wen_wb, retired} !== {1'b1, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL async_pre: got wb_valid=%b wb_wen_wb=%b retired=%0d expected 1 1 1",
                     wb_valid, wb_wen_wb, retired);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        obs = {if_valid, id_valid, exe_valid, mem_valid, wb_valid, wb_wen_exe, wb_wen_mem,
               wb_wen_wb, retired[1:0]};
        checks++;
        if (obs !== 10'd0 || retired !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: got %b retired=%0d expected all zero", obs, retired);
        end
        rst = 1'b0;
    endtask

    task automatic test_addi();
        do_reset();
        tick(); tick();
        set_decode(32'h20050007, WB_ADDR_RT, 1'b1, 1'b0, 1'b0, 1'b0, WB_DATA_ALU);
        tick();
        checks++;
        if (regw_addr_exe !== 5'd5 || wb_wen_exe !== 1'b1) begin
            errors++;
            $display("FAIL addi_exe: got addr=%0d wen=%b expected 5 1", regw_addr_exe, wb_wen_exe);
        end
        set_decode(32'h0, WB_ADDR_RD, 1'b0, 1'b0, 1'b0, 1'b0, WB_DATA_ALU);
        tick();
        checks++;
        if (regw_addr_mem !== 5'd5 || wb_wen_mem !== 1'b1 || wb_wen_exe !== 1'b0) begin
            errors++;
            $display("FAIL addi_mem: got addr=%0d wen_mem=%b wen_exe=%b expected 5 1 0",
                     regw_addr_mem, wb_wen_mem, wb_wen_exe);
        end
        tick();
        checks++;
        if (regw_addr_wb !== 5'd5 || wb_wen_wb !== 1'b1 || retired !== 4'd0) begin
            errors++;
            $display("FAIL addi_wb: got addr=%0d wen=%b retired=%0d expected 5 1 0",
                     regw_addr_wb, wb_wen_wb, retired);
        end
        tick();
        checks++;
        if (retired !== 4'd1) begin
            errors++;
            $display("FAIL addi_retire: got %0d expected 1", retired);
        end
    endtask

    task automatic test_load_stall();
        do_reset();
        tick(); tick();
        set_decode(32'h8C030000, WB_ADDR_RT, 1'b1, 1'b1, 1'b0, 1'b1, WB_DATA_MEM);
        tick();
        checks++;
        if (is_load_exe !== 1'b1 || regw_addr_exe !== 5'd3) begin
            errors++;
            $display("FAIL lw_exe: got load=%b addr=%0d expected 1 3", is_load_exe, regw_addr_exe);
        end
        set_decode(32'h00632020, WB_ADDR_RD, 1'b1, 1'b0, 1'b0, 1'b0, WB_DATA_ALU);
        if_en = 1'b0; id_en = 1'b0; exe_rst = 1'b1;
        tick();
        checks++;
        if ({exe_valid, wb_wen_exe, is_load_exe, mem_ren_mem, id_valid} !== 5'b00011
            || regw_addr_mem !== 5'd3) begin
            errors++;
            $display("FAIL stall: got exe_v=%b wen=%b load=%b mren=%b id_v=%b maddr=%0d expected 0 0 0 1 1 3",
                     exe_valid, wb_wen_exe, is_load_exe, mem_ren_mem, id_valid, regw_addr_mem);
        end
        if_en = 1'b1; id_en = 1'b1; exe_rst = 1'b0;
        tick();
        checks++;
        if ({exe_valid, wb_wen_exe, mem_valid, wb_data_src_wb} !== 4'b1101
            || regw_addr_exe !== 5'd4 || regw_addr_wb !== 5'd3) begin
            errors++;
            $display("FAIL after_stall: got exe_v=%b wen=%b mem_v=%b ds=%b eaddr=%0d waddr=%0d expected 1 1 0 1 4 3",
                     exe_valid, wb_wen_exe, mem_valid, wb_data_src_wb, regw_addr_exe, regw_addr_wb);
        end
    endtask

    task automatic test_jal();
        do_reset();
        tick(); tick();
        set_decode(32'h0C000010, WB_ADDR_LINK, 1'b1, 1'b0, 1'b0, 1'b0, WB_DATA_ALU);
        tick();
        checks++;
        if (regw_addr_exe !== 5'd31 || wb_wen_exe !== 1'b1) begin
            errors++;
            $display("FAIL jal: got addr=%0d wen=%b expected 31 1", regw_addr_exe, wb_wen_exe);
        end
        set_decode(32'hFFFFFFFF, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, WB_DATA_ALU);
        tick();
        checks++;
        if (regw_addr_exe !== 5'd0 || wb_wen_exe !== 1'b1) begin
            errors++;
            $display("FAIL bad_src: got addr=%0d wen=%b expected 0 1", regw_addr_exe, wb_wen_exe);
        end
    endtask

    task automatic test_mem_rst_en();
        do_reset();
        tick(); tick();
        set_decode(32'h00003820, WB_ADDR_RD, 1'b1, 1'b0, 1'b1, 1'b0, WB_DATA_ALU);
        tick();
        set_decode(32'h00004820, WB_ADDR_RD, 1'b1, 1'b0, 1'b0, 1'b0, WB_DATA_ALU);
        tick();
        checks++;
        if (regw_addr_mem !== 5'd7 || mem_wen_mem !== 1'b1 || exe_valid !== 1'b1) begin
            errors++;
            $display("FAIL mem_pre: got addr=%0d mwen=%b exe_v=%b expected 7 1 1",
                     regw_addr_mem, mem_wen_mem, exe_valid);
        end
        mem_rst = 1'b1; mem_en = 1'b1;
        tick();
        mem_rst = 1'b0;
        checks++;
        if ({mem_valid, mem_wen_mem, wb_wen_mem, wb_valid, wb_wen_wb} !== 5'b00011
            || regw_addr_mem !== 5'd0 || regw_addr_wb !== 5'd7) begin
            errors++;
            $display("FAIL mem_flush: got mem_v=%b mwen=%b wen_m=%b wb_v=%b wen_wb=%b maddr=%0d waddr=%0d expected 0 0 0 1 1 0 7",
                     mem_valid, mem_wen_mem, wb_wen_mem, wb_valid, wb_wen_wb, regw_addr_mem, regw_addr_wb);
        end
    endtask

    task automatic test_retire_wrap();
        do_reset();
        set_decode(32'h00002020, WB_ADDR_RD, 1'b1, 1'b0, 1'b0, 1'b0, WB_DATA_ALU);
        repeat (20) tick();
        checks++;
        if (retired !== 4'd15) begin
            errors++;
            $display("FAIL retire_max: got %0d expected 15", retired);
        end
        tick();
        checks++;
        if (retired !== 4'd0) begin
            errors++;
            $display("FAIL retire_wrap: got %0d expected 0", retired);
        end
    endtask

    task automatic test_random();
        logic [30:0] obs, exp;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if_rst  = ($urandom % 10 == 0); if_en  = ($urandom % 4 != 0);
            id_rst  = ($urandom % 10 == 0); id_en  = ($urandom % 4 != 0);
            exe_rst = ($urandom % 10 == 0); exe_en = ($urandom % 4 != 0);
            mem_rst = ($urandom % 10 == 0); mem_en = ($urandom % 4 != 0);
            wb_rst  = ($urandom % 10 == 0); wb_en  = ($urandom % 4 != 0);
            set_decode($urandom, 2'($urandom % 4), 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom));
            if ($urandom % 60 == 0) begin
                rst = 1'b1;
                model_reset();
                #2;
                rst = 1'b0;
            end
            tick();
            obs = {if_valid, id_valid, exe_valid, mem_valid, wb_valid, regw_addr_exe, regw_addr_mem,
                   regw_addr_wb, wb_wen_exe, wb_wen_mem, wb_wen_wb, is_load_exe, mem_ren_mem,
                   mem_wen_mem, wb_data_src_wb, retired};
            exp = {m_if, m_id, m_exe.v, m_mem.v, m_wb.v, m_exe.ra, m_mem.ra, m_wb.ra,
                   m_exe.v & m_exe.wen, m_mem.v & m_mem.wen, m_wb.v & m_wb.wen,
                   m_exe.v & m_exe.ld, m_mem.v & m_mem.ren, m_mem.v & m_mem.mwen,
                   m_wb.ds, 4'(m_ret)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random cyc %0d: got %h expected %h", cyc, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_stall();
        test_jal();
        test_mem_rst_en();
        test_retire_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
